// File: rtl/adc_capture_if.sv
// FIFO read side of adc_capture: the head frame, fill level and sticky flags,
// plus the pop and flag-clear requests coming back from the consumer.
interface adc_capture_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    logic                   rd_en;
    logic                   clr_flags;
    logic [DATA_W-1:0]      LDATA_OUT;
    logic [DATA_W-1:0]      RDATA_OUT;
    logic                   valid;
    logic [$clog2(DEPTH):0] fill;
    logic                   overflow;
    logic                   short_err;

    modport master (
        input  rd_en, clr_flags,
        output LDATA_OUT, RDATA_OUT, valid, fill, overflow, short_err
    );

    modport slave (
        output rd_en, clr_flags,
        input  LDATA_OUT, RDATA_OUT, valid, fill, overflow, short_err
    );
endinterface

// File: rtl/adc_capture.sv
// WM8731 ADC-side I2S receiver: oversamples the codec pins in the Clk domain,
// deserializes left/right words and queues stereo frames in a show-ahead FIFO.
module adc_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CW     = 6
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          AUD_BCLK,
    input  logic          AUD_ADCLRCK,
    input  logic          AUD_ADCDAT,
    adc_capture_if.master rd
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DATA_W);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DATA_W - 1);
    localparam logic [AW:0]   FULL_FILL = (AW + 1)'(DEPTH);
    localparam logic          CH_L      = 1'b0;
    localparam logic          CH_R      = 1'b1;

    typedef enum logic [2:0] {IDLE, ALIGN, DELAY, SHIFT, DONE} state_t;

    // Left-justify a possibly short word; missing LSBs come out as zeros.
    function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] s,
                                                     input logic [CW-1:0]     n);
        return s << (FULL_CNT - n);
    endfunction

    logic [2:0] bclk_q, lrck_q;
    logic [1:0] dat_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bclk_q <= '0;
            lrck_q <= '0;
            dat_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], AUD_BCLK};
            lrck_q <= {lrck_q[1:0], AUD_ADCLRCK};
            dat_q  <= {dat_q[0], AUD_ADCDAT};
        end
    end

    logic bclk_rise, lrck_rise, lrck_fall;
    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign lrck_rise = lrck_q[1] & ~lrck_q[2];
    assign lrck_fall = ~lrck_q[1] & lrck_q[2];

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              chan_q, chan_d;
    logic [DATA_W-1:0] lword_q, lword_d;
    logic [DATA_W-1:0] word;
    logic              push, short_set;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            chan_q  <= CH_L;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            chan_q  <= chan_d;
        end
        lword_q <= lword_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        chan_d    = chan_q;
        lword_d   = lword_q;
        push      = 1'b0;
        short_set = 1'b0;
        word      = align_word(sh_q, cnt_q);
        if (!Enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            chan_d  = CH_L;
        end else begin
            case (state_q)
                IDLE:  state_d = ALIGN;
                ALIGN: if (lrck_fall) begin
                    state_d = DELAY;
                    chan_d  = CH_L;
                end
                DELAY: if (bclk_rise) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
                SHIFT, DONE: begin
                    if ((lrck_fall && chan_q == CH_R) || (lrck_rise && chan_q == CH_L)) begin
                        short_set = (cnt_q < FULL_CNT);
                        state_d   = DELAY;
                        chan_d    = ~chan_q;
                        if (chan_q == CH_R) push = 1'b1;
                        else                lword_d = word;
                    end else if (lrck_fall || lrck_rise) begin
                        // Frame clock out of step with our channel: drop and resync.
                        state_d = ALIGN;
                    end else if (state_q == SHIFT && bclk_rise) begin
                        sh_d  = {sh_q[DATA_W-2:0], dat_q[1]};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] mem_l_q [DEPTH];
    logic [DATA_W-1:0] mem_r_q [DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       fill_q, fill_d;
    logic              ovf_q, short_q;
    logic              pop, full, wr_en, ovf_set;

    assign pop     = rd.rd_en & (fill_q != '0);
    assign full    = (fill_q == FULL_FILL);
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        fill_d = fill_q;
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            if (wr_en) wp_q <= wp_q + 1'b1;
            if (pop)   rp_q <= rp_q + 1'b1;
            fill_q  <= fill_d;
            ovf_q   <= ovf_set | (ovf_q & ~rd.clr_flags);
            short_q <= short_set | (short_q & ~rd.clr_flags);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_l_q[wp_q] <= lword_q;
            mem_r_q[wp_q] <= word;
        end
    end

    assign rd.valid     = (fill_q != '0);
    assign rd.fill      = fill_q;
    assign rd.LDATA_OUT = rd.valid ? mem_l_q[rp_q] : '0;
    assign rd.RDATA_OUT = rd.valid ? mem_r_q[rp_q] : '0;
    assign rd.overflow  = ovf_q;
    assign rd.short_err = short_q;
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: drives I2S frames on the codec pins and compares the
// FIFO outputs every cycle against a frame-level queue model.
module tb_adc_capture;
    localparam int DEPTH = 4;

    logic Clk = 1'b0;
    logic Reset, Enable, bclk, lrck, dat;

    adc_capture_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();

    adc_capture #(.DATA_W(16), .DEPTH(DEPTH), .CW(6)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .rd          (bus)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct { int due; bit is_push; logic [15:0] l; logic [15:0] r; } ev_t;
    typedef struct { logic [15:0] l; logic [15:0] r; } fr_t;
    ev_t evq[$];
    fr_t mq[$];
    bit  m_ovf, m_short;

    // Protocol tracker: what the receiver should make of each LRCK edge.
    bit          cap, in_l;
    logic [15:0] tr_l, prev_w;
    int          prev_n;

    function automatic logic [15:0] align16(input logic [15:0] w, input int n);
        logic [31:0] t;
        if (n == 0) return 16'h0;
        t = 32'(w) << (16 - n);
        return t[15:0];
    endfunction

    function automatic void sched(input bit is_push, input logic [15:0] l, input logic [15:0] r);
        ev_t e;
        e.due = cyc + 3; e.is_push = is_push; e.l = l; e.r = r;
        evq.push_back(e);
    endfunction

    function automatic void on_edge(input bit lr);
        if (!lr) begin
            if (cap && !in_l) begin
                sched(1'b1, tr_l, align16(prev_w, prev_n));
                if (prev_n < 16) sched(1'b0, 16'h0, 16'h0);
            end
            cap  = Enable;
            in_l = Enable;
        end else if (cap && in_l) begin
            tr_l = align16(prev_w, prev_n);
            if (prev_n < 16) sched(1'b0, 16'h0, 16'h0);
            in_l = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit  pop, have_push, set_sh;
        int  pre;
        fr_t f;
        ev_t e;
        if (Reset) begin
            mq.delete(); evq.delete();
            m_ovf = 1'b0; m_short = 1'b0;
            return;
        end
        pre = mq.size();
        pop = bus.rd_en && (pre > 0);
        have_push = 1'b0; set_sh = 1'b0;
        while (evq.size() > 0 && evq[0].due <= cyc) begin
            e = evq.pop_front();
            if (e.is_push) begin have_push = 1'b1; f.l = e.l; f.r = e.r; end
            else set_sh = 1'b1;
        end
        if (bus.clr_flags) begin m_ovf = 1'b0; m_short = 1'b0; end
        if (pop) void'(mq.pop_front());
        if (have_push) begin
            if (pre < DEPTH || pop) mq.push_back(f);
            else m_ovf = 1'b1;
        end
        if (set_sh) m_short = 1'b1;
    endfunction

    initial begin
        logic [37:0] act, exp;
        forever begin
            @(posedge Clk);
            cyc++;
            model_step();
            #1;
            act = {bus.valid, bus.fill, bus.LDATA_OUT, bus.RDATA_OUT, bus.overflow, bus.short_err};
            exp[37]    = (mq.size() > 0);
            exp[36:34] = 3'(mq.size());
            exp[33:18] = (mq.size() > 0) ? mq[0].l : 16'h0;
            exp[17:2]  = (mq.size() > 0) ? mq[0].r : 16'h0;
            exp[1]     = m_ovf;
            exp[0]     = m_short;
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL outputs cyc=%0d got v/fill/L/R/ov/se=%b/%0d/%h/%h/%b/%b want %b/%0d/%h/%h/%b/%b",
                         cyc, act[37], act[36:34], act[33:18], act[17:2], act[1], act[0],
                         exp[37], exp[36:34], exp[33:18], exp[17:2], exp[1], exp[0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_enable(input bit v);
        Enable = v;
        if (!v) begin cap = 1'b0; in_l = 1'b0; end
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.valid), 32'h0);
        check({tag, "_fill"}, 32'(bus.fill), 32'h0);
        check({tag, "_L"}, 32'(bus.LDATA_OUT), 32'h0);
        check({tag, "_R"}, 32'(bus.RDATA_OUT), 32'h0);
        check({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
        check({tag, "_short"}, 32'(bus.short_err), 32'h0);
    endtask

    // One LRCK half: BCLK period 16 Clk, data/LRCK change on BCLK fall,
    // first BCLK is the I2S delay slot, then n data bits MSB first.
    task automatic send_half(input bit lr, input logic [15:0] w, input int n, input int total,
                             input int en_at, input bit pop_edge, input int rst_at);
        for (int i = 0; i < total; i++) begin
            bclk = 1'b0;
            if (i == 0 && lr != lrck) begin lrck = lr; on_edge(lr); end
            dat = (i >= 1 && i <= n) ? w[n - i] : 1'b0;
            if (i == en_at) set_enable(1'b1);
            if (i == 0 && pop_edge) begin
                tick(2); bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0; tick(5);
            end else if (i == rst_at) begin
                tick(1); Reset = 1'b1; cap = 1'b0; in_l = 1'b0; tick(1);
                check_zero("midrst");
                Reset = 1'b0; tick(6);
            end else begin
                tick(8);
            end
            bclk = 1'b1;
            tick(8);
        end
        prev_w = w;
        prev_n = n;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n, input int total);
        send_half(1'b0, l, n, total, -1, 1'b0, -1);
        send_half(1'b1, r, n, total, -1, 1'b0, -1);
    endtask

    task automatic closing_half(input bit pop_edge);
        send_half(1'b0, 16'h0, 0, 32, -1, pop_edge, -1);
        set_enable(1'b0);
    endtask

    task automatic dummy_r();
        send_half(1'b1, 16'h0, 0, 32, -1, 1'b0, -1);
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
        bus.rd_en = 1'b0; bus.clr_flags = 1'b0;
        cap = 1'b0; in_l = 1'b0; tr_l = '0; prev_w = '0; prev_n = 0;
        m_ovf = 1'b0; m_short = 1'b0;
        tick(3);
        check_zero("reset");
        Reset = 1'b0;
        tick(2);

        // Basic capture
        set_enable(1'b1);
        dummy_r();
        send_frame(16'hA55A, 16'h1234, 16, 32);
        closing_half(1'b0);
        check("basic_valid", 32'(bus.valid), 32'h1);
        check("basic_L", 32'(bus.LDATA_OUT), 32'hA55A);
        check("basic_R", 32'(bus.RDATA_OUT), 32'h1234);
        check("basic_fill", 32'(bus.fill), 32'h1);
        pop_one();
        check("basic_pop_valid", 32'(bus.valid), 32'h0);

        // Alignment: enable rises mid right half
        dummy_r();
        send_half(1'b0, 16'h1111, 16, 32, -1, 1'b0, -1);
        send_half(1'b1, 16'h2222, 16, 32, 10, 1'b0, -1);
        send_frame(16'h3333, 16'h4444, 16, 32);
        closing_half(1'b0);
        check("align_fill", 32'(bus.fill), 32'h1);
        check("align_L", 32'(bus.LDATA_OUT), 32'h3333);
        check("align_R", 32'(bus.RDATA_OUT), 32'h4444);
        pop_one();

        // Short words: 12 data bits per channel
        set_enable(1'b1);
        dummy_r();
        send_frame(16'h0ABC, 16'h0567, 12, 13);
        closing_half(1'b0);
        check("short_L", 32'(bus.LDATA_OUT), 32'hABC0);
        check("short_R", 32'(bus.RDATA_OUT), 32'h5670);
        check("short_flag", 32'(bus.short_err), 32'h1);
        bus.clr_flags = 1'b1; tick(1); bus.clr_flags = 1'b0;
        check("short_clr", 32'(bus.short_err), 32'h0);
        pop_one();

        // Overflow: five frames into a four-deep FIFO
        set_enable(1'b1);
        dummy_r();
        for (int k = 1; k <= 5; k++) send_frame(16'(k), 16'(k), 16, 32);
        closing_half(1'b0);
        check("ovf_fill", 32'(bus.fill), 32'h4);
        check("ovf_flag", 32'(bus.overflow), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_pop_L", 32'(bus.LDATA_OUT), 32'(k));
            check("ovf_pop_R", 32'(bus.RDATA_OUT), 32'(k));
            pop_one();
        end
        check("ovf_empty", 32'(bus.valid), 32'h0);
        bus.clr_flags = 1'b1; tick(1); bus.clr_flags = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 32'h0);

        // Push and pop on the same cycle while full
        set_enable(1'b1);
        dummy_r();
        for (int k = 0; k <= 4; k++) send_frame(16'h0010 + 16'(k), 16'h0020 + 16'(k), 16, 32);
        closing_half(1'b1);
        check("fullpp_fill", 32'(bus.fill), 32'h4);
        check("fullpp_ovf", 32'(bus.overflow), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            check("fullpp_L", 32'(bus.LDATA_OUT), 32'h10 + 32'(k));
            pop_one();
        end
        check("fullpp_last_L", 32'(bus.LDATA_OUT), 32'h14);
        check("fullpp_last_R", 32'(bus.RDATA_OUT), 32'h24);

        // Reset after 7 left bits, then recapture from a fresh frame
        set_enable(1'b1);
        dummy_r();
        send_half(1'b0, 16'h7777, 16, 32, -1, 1'b0, 8);
        send_half(1'b1, 16'h8888, 16, 32, -1, 1'b0, -1);
        send_frame(16'hBEEF, 16'hCAFE, 16, 32);
        closing_half(1'b0);
        check("rst_fill", 32'(bus.fill), 32'h1);
        check("rst_L", 32'(bus.LDATA_OUT), 32'hBEEF);
        check("rst_R", 32'(bus.RDATA_OUT), 32'hCAFE);
        pop_one();
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
